mem_port_arbiter: RTL

Shares one single-port synchronous instruction/data memory between the fetch stage (IF) and the memory-access stage (DM) of the pipelined RISC-V core. It grants at most one request per cycle and returns read data one cycle after the grant, tagged to the requester that owns it. Grant priority is data-first, bounded by a starvation limit. Losing requesters receive stall signals that freeze their pipeline stage.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 49 ++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_stall;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_stall, if_rvalid, if_rdata, dm_gnt, dm_stall, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_stall, if_rvalid, if_rdata, dm_gnt, dm_stall, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-first arbitration of one memory port between fetch and data access
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.slave   bus,
  output logic [15:0]         conflict_cnt
);
  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_DM} rsp_t;
  localparam logic [3:0] MAX = 4'(MAX_DATA_STREAK);
  rsp_t       rsp_q, rsp_d;
  logic [3:0] streak_q, streak_d;
  logic       both, if_gnt, dm_gnt, unused_addr;
  always_comb begin
    both          = bus.if_req & bus.dm_req;
    dm_gnt        = resetn & bus.dm_req & ~(bus.if_req & (streak_q == MAX));
    if_gnt        = resetn & bus.if_req & ~dm_gnt;
    bus.if_gnt    = if_gnt;
    bus.dm_gnt    = dm_gnt;
    bus.if_stall  = resetn & bus.if_req & ~if_gnt;
    bus.dm_stall  = resetn & bus.dm_req & ~dm_gnt;
    bus.mem_en    = if_gnt | dm_gnt;
    bus.mem_we    = (dm_gnt & bus.dm_we) ? bus.dm_be : 4'b0000;
    bus.mem_addr  = dm_gnt ? bus.dm_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2];
    bus.mem_wdata = bus.dm_wdata;
    // resetn gating kills the response of a read granted just before reset
    bus.if_rvalid = resetn & (rsp_q == RSP_IF);
    bus.dm_rvalid = resetn & (rsp_q == RSP_DM);
    bus.if_rdata  = bus.mem_rdata;
    bus.dm_rdata  = bus.mem_rdata;
    rsp_d         = if_gnt ? RSP_IF : (dm_gnt & ~bus.dm_we) ? RSP_DM : RSP_NONE;
    streak_d      = (!bus.if_req || if_gnt) ? 4'd0 : dm_gnt ? streak_q + 4'd1 : streak_q;
    unused_addr   = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_q        <= RSP_NONE;
      streak_q     <= 4'd0;
      conflict_cnt <= 16'd0;
    end else begin
      rsp_q    <= rsp_d;
      streak_q <= streak_d;
      if (both && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
endmodule
